// File: rtl/pipeline_stall_controller_if.sv
// Hazard-scheduler bus between the pipeline datapath and the stall controller.
// The datapath drives the ID/EX/MEM hazard information; the controller returns enables and MDU status.
interface pipeline_stall_controller_if #(
    parameter int unsigned CNT_WIDTH  = 4,
    parameter int unsigned PERF_WIDTH = 32
);
    logic [4:0]            id_rs_addr;
    logic [4:0]            id_rt_addr;
    logic [1:0]            id_rs_tuse;
    logic [1:0]            id_rt_tuse;
    logic [4:0]            ex_dst_addr;
    logic [1:0]            ex_tnew;
    logic [4:0]            mem_dst_addr;
    logic [1:0]            mem_tnew;
    logic                  id_md_start;
    logic                  id_md_is_div;
    logic                  id_md_use;

    logic                  pc_enable;
    logic                  if_id_enable;
    logic                  id_ex_clear;
    logic                  md_busy;
    logic [CNT_WIDTH-1:0]  md_count;
    logic                  md_done;
    logic [PERF_WIDTH-1:0] stall_count;

    modport master (
        output id_rs_addr, id_rt_addr, id_rs_tuse, id_rt_tuse,
               ex_dst_addr, ex_tnew, mem_dst_addr, mem_tnew,
               id_md_start, id_md_is_div, id_md_use,
        input  pc_enable, if_id_enable, id_ex_clear,
               md_busy, md_count, md_done, stall_count
    );

    modport slave (
        input  id_rs_addr, id_rt_addr, id_rs_tuse, id_rt_tuse,
               ex_dst_addr, ex_tnew, mem_dst_addr, mem_tnew,
               id_md_start, id_md_is_div, id_md_use,
        output pc_enable, if_id_enable, id_ex_clear,
               md_busy, md_count, md_done, stall_count
    );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Central hazard scheduler: Tuse/Tnew register hazards, MDU occupancy tracking,
// pipeline enable/clear generation and a saturating stall-cycle counter.
module pipeline_stall_controller #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter int unsigned CNT_WIDTH   = 4,
    parameter int unsigned PERF_WIDTH  = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    pipeline_stall_controller_if.slave  bus
);

    localparam logic [CNT_WIDTH-1:0]  CNT_ZERO  = '0;
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_MULT  = CNT_WIDTH'(MULT_CYCLES);
    localparam logic [CNT_WIDTH-1:0]  CNT_DIV   = CNT_WIDTH'(DIV_CYCLES);
    localparam logic [PERF_WIDTH-1:0] PERF_MAX  = '1;
    localparam logic [PERF_WIDTH-1:0] PERF_ONE  = PERF_WIDTH'(1);

    logic [CNT_WIDTH-1:0]  md_count_q;
    logic [CNT_WIDTH-1:0]  md_count_nxt;
    logic                  md_done_q;
    logic                  md_done_nxt;
    logic [PERF_WIDTH-1:0] stall_count_q;
    logic [PERF_WIDTH-1:0] stall_count_nxt;

    logic                  hz_rs_ex;
    logic                  hz_rt_ex;
    logic                  hz_rs_mem;
    logic                  hz_rt_mem;
    logic                  md_hz;
    logic                  md_busy_c;
    logic                  stall_c;

    // A source hazards when a younger producer will not have its value ready in time.
    // tuse=3 can never be below a 2-bit tnew, so unused sources drop out naturally.
    function automatic logic src_hazard(
        input logic [4:0] src_addr,
        input logic [1:0] src_tuse,
        input logic [4:0] dst_addr,
        input logic [1:0] tnew
    );
        return (src_addr != 5'd0) && (src_addr == dst_addr) && (src_tuse < tnew);
    endfunction

    // Hazard detection and stall decision, same cycle as the inputs.
    always_comb begin
        hz_rs_ex  = src_hazard(bus.id_rs_addr, bus.id_rs_tuse, bus.ex_dst_addr,  bus.ex_tnew);
        hz_rt_ex  = src_hazard(bus.id_rt_addr, bus.id_rt_tuse, bus.ex_dst_addr,  bus.ex_tnew);
        hz_rs_mem = src_hazard(bus.id_rs_addr, bus.id_rs_tuse, bus.mem_dst_addr, bus.mem_tnew);
        hz_rt_mem = src_hazard(bus.id_rt_addr, bus.id_rt_tuse, bus.mem_dst_addr, bus.mem_tnew);
        md_busy_c = (md_count_q != CNT_ZERO);
        md_hz     = bus.id_md_use && md_busy_c;
        stall_c   = hz_rs_ex || hz_rt_ex || hz_rs_mem || hz_rt_mem || md_hz;
    end

    // Next-state for MDU occupancy, completion pulse and perf counter.
    // A start while busy is always stalled by md_hz, so load and decrement are exclusive;
    // load still wins if a malformed start arrives without id_md_use.
    always_comb begin
        md_count_nxt    = md_count_q;
        md_done_nxt     = 1'b0;
        stall_count_nxt = stall_count_q;

        if (bus.id_md_start && !stall_c) begin
            md_count_nxt = bus.id_md_is_div ? CNT_DIV : CNT_MULT;
        end else if (md_busy_c) begin
            md_count_nxt = md_count_q - CNT_ONE;
            md_done_nxt  = (md_count_q == CNT_ONE);
        end

        if (stall_c && (stall_count_q != PERF_MAX)) begin
            stall_count_nxt = stall_count_q + PERF_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_count_q    <= CNT_ZERO;
            md_done_q     <= 1'b0;
            stall_count_q <= '0;
        end else begin
            md_count_q    <= md_count_nxt;
            md_done_q     <= md_done_nxt;
            stall_count_q <= stall_count_nxt;
        end
    end

    assign bus.pc_enable    = ~stall_c;
    assign bus.if_id_enable = ~stall_c;
    assign bus.id_ex_clear  = stall_c;
    assign bus.md_busy      = md_busy_c;
    assign bus.md_count     = md_count_q;
    assign bus.md_done      = md_done_q;
    assign bus.stall_count  = stall_count_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Randomized scoreboard bench for pipeline_stall_controller, with a second narrow-counter
// instance sharing the same stimulus to exercise stall_count saturation.
module tb_pipeline_stall_controller;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] rs_tuse;
        logic [1:0] rt_tuse;
        logic [4:0] ex_dst;
        logic [1:0] ex_tnew;
        logic [4:0] mem_dst;
        logic [1:0] mem_tnew;
        logic       start;
        logic       is_div;
        logic       use_md;
    } stim_t;

    typedef struct {
        bit     pc_en;
        bit     if_en;
        bit     clr;
        bit     busy;
        bit     done;
        int     count;
        longint scnt;
        longint scnt_sat;
    } exp_t;

    logic  clk = 1'b0;
    logic  reset = 1'b0;
    stim_t cur;

    int checks = 0;
    int errors = 0;

    exp_t exp_q[$];

    // Reference state: plain integers describing what the spec says should have happened.
    int     m_rem  = 0;
    bit     m_done = 0;
    longint m_scnt = 0;

    pipeline_stall_controller_if #(.CNT_WIDTH(4), .PERF_WIDTH(32)) bus  ();
    pipeline_stall_controller_if #(.CNT_WIDTH(4), .PERF_WIDTH(4))  bus4 ();

    pipeline_stall_controller #(
        .MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_WIDTH(4), .PERF_WIDTH(32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    pipeline_stall_controller #(
        .MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_WIDTH(4), .PERF_WIDTH(4)
    ) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4.slave)
    );

    assign bus.id_rs_addr    = cur.rs;
    assign bus.id_rt_addr    = cur.rt;
    assign bus.id_rs_tuse    = cur.rs_tuse;
    assign bus.id_rt_tuse    = cur.rt_tuse;
    assign bus.ex_dst_addr   = cur.ex_dst;
    assign bus.ex_tnew       = cur.ex_tnew;
    assign bus.mem_dst_addr  = cur.mem_dst;
    assign bus.mem_tnew      = cur.mem_tnew;
    assign bus.id_md_start   = cur.start;
    assign bus.id_md_is_div  = cur.is_div;
    assign bus.id_md_use     = cur.use_md;

    assign bus4.id_rs_addr   = cur.rs;
    assign bus4.id_rt_addr   = cur.rt;
    assign bus4.id_rs_tuse   = cur.rs_tuse;
    assign bus4.id_rt_tuse   = cur.rt_tuse;
    assign bus4.ex_dst_addr  = cur.ex_dst;
    assign bus4.ex_tnew      = cur.ex_tnew;
    assign bus4.mem_dst_addr = cur.mem_dst;
    assign bus4.mem_tnew     = cur.mem_tnew;
    assign bus4.id_md_start  = cur.start;
    assign bus4.id_md_is_div = cur.is_div;
    assign bus4.id_md_use    = cur.use_md;

    always #5 clk = ~clk;

    function automatic stim_t idle();
        stim_t s;
        s.rs = 5'd0;  s.rt = 5'd0;  s.rs_tuse = 2'd3; s.rt_tuse = 2'd3;
        s.ex_dst = 5'd0; s.ex_tnew = 2'd0; s.mem_dst = 5'd0; s.mem_tnew = 2'd0;
        s.start = 1'b0; s.is_div = 1'b0; s.use_md = 1'b0;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.rs       = 5'($urandom_range(0, 3));
        s.rt       = 5'($urandom_range(0, 3));
        s.rs_tuse  = 2'($urandom_range(0, 3));
        s.rt_tuse  = 2'($urandom_range(0, 3));
        s.ex_dst   = 5'($urandom_range(0, 3));
        s.ex_tnew  = 2'($urandom_range(0, 3));
        s.mem_dst  = 5'($urandom_range(0, 3));
        s.mem_tnew = 2'($urandom_range(0, 3));
        s.start    = ($urandom_range(0, 7) == 0);
        s.is_div   = 1'($urandom_range(0, 1));
        s.use_md   = s.start || ($urandom_range(0, 2) == 0);
        return s;
    endfunction

    // A value needed in `tuse` cycles is late if its producer needs `tnew` more cycles.
    function automatic bit model_stall(input stim_t s);
        int addr [2];
        int tuse [2];
        bit st = 0;
        addr[0] = int'(s.rs); tuse[0] = int'(s.rs_tuse);
        addr[1] = int'(s.rt); tuse[1] = int'(s.rt_tuse);
        for (int i = 0; i < 2; i++) begin
            if (addr[i] != 0 && tuse[i] != 3) begin
                if (addr[i] == int'(s.ex_dst)  && tuse[i] < int'(s.ex_tnew))  st = 1;
                if (addr[i] == int'(s.mem_dst) && tuse[i] < int'(s.mem_tnew)) st = 1;
            end
        end
        if (s.use_md && m_rem > 0) st = 1;
        return st;
    endfunction

    // One clock cycle of the reference: stall accounting, MDU issue/drain.
    task automatic model_edge(input stim_t s, input bit st);
        if (st) m_scnt++;
        if (s.start && !st) begin
            m_rem  = s.is_div ? 10 : 5;
            m_done = 0;
        end else if (m_rem > 0) begin
            m_rem--;
            m_done = (m_rem == 0);
        end else begin
            m_done = 0;
        end
    endtask

    task automatic step(input stim_t s, input bit rst_v);
        exp_t e;
        bit   st;
        @(negedge clk);
        cur   = s;
        reset = rst_v;
        if (!rst_v) begin
            m_rem = 0; m_done = 0; m_scnt = 0;
        end
        st         = model_stall(s);
        e.pc_en    = !st;
        e.if_en    = !st;
        e.clr      = st;
        e.busy     = (m_rem > 0);
        e.done     = m_done;
        e.count    = m_rem;
        e.scnt     = m_scnt;
        e.scnt_sat = (m_scnt > 15) ? 15 : m_scnt;
        exp_q.push_back(e);
        if (rst_v) model_edge(s, st);
    endtask

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    // Monitor: every cycle the DUT presents its outputs; compare against queued expectations.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc_enable",       longint'(bus.pc_enable),    longint'(e.pc_en));
                chk("if_id_enable",    longint'(bus.if_id_enable), longint'(e.if_en));
                chk("id_ex_clear",     longint'(bus.id_ex_clear),  longint'(e.clr));
                chk("md_busy",         longint'(bus.md_busy),      longint'(e.busy));
                chk("md_count",        longint'(bus.md_count),     longint'(e.count));
                chk("md_done",         longint'(bus.md_done),      longint'(e.done));
                chk("stall_count",     longint'(bus.stall_count),  e.scnt);
                chk("stall_count_sat", longint'(bus4.stall_count), e.scnt_sat);
            end
        end
    end

    initial begin
        stim_t s;
        cur = idle();

        // Reset state, then release.
        step(idle(), 1'b0);
        step(idle(), 1'b1);
        step(idle(), 1'b1);

        // Load-use: stalls while ex_tnew=2, clears once ex_tnew=1.
        s = idle(); s.rs = 5'd8; s.rs_tuse = 2'd1; s.ex_dst = 5'd8; s.ex_tnew = 2'd2;
        step(s, 1'b1);
        s.ex_tnew = 2'd1;
        step(s, 1'b1);

        // $0 never hazards; tuse=3 never hazards.
        s = idle(); s.rs_tuse = 2'd0; s.ex_tnew = 2'd2;
        step(s, 1'b1);
        s = idle(); s.rt = 5'd9; s.rt_tuse = 2'd3; s.ex_dst = 5'd9; s.ex_tnew = 2'd3;
        s.mem_dst = 5'd9; s.mem_tnew = 2'd3;
        step(s, 1'b1);

        // mult followed by a dependent mfhi held until the MDU drains.
        s = idle(); s.start = 1'b1; s.use_md = 1'b1;
        step(s, 1'b1);
        s = idle(); s.use_md = 1'b1;
        for (int i = 0; i < 7; i++) step(s, 1'b1);

        // div blocked by a register hazard, then issued once it clears.
        s = idle(); s.start = 1'b1; s.is_div = 1'b1; s.use_md = 1'b1;
        s.rs = 5'd5; s.rs_tuse = 2'd0; s.ex_dst = 5'd5; s.ex_tnew = 2'd1;
        step(s, 1'b1);
        step(s, 1'b1);
        s.ex_tnew = 2'd0;
        step(s, 1'b1);
        for (int i = 0; i < 4; i++) step(idle(), 1'b1);

        // Reset in the middle of the divide, asserted between clock edges.
        step(idle(), 1'b0);
        step(idle(), 1'b0);
        for (int i = 0; i < 3; i++) step(idle(), 1'b1);

        // Long stall to push the narrow counter into saturation.
        s = idle(); s.rt = 5'd3; s.rt_tuse = 2'd0; s.mem_dst = 5'd3; s.mem_tnew = 2'd2;
        for (int i = 0; i < 20; i++) step(s, 1'b1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step(rand_stim(), ($urandom_range(0, 299) != 0));
        end

        step(idle(), 1'b1);
        @(negedge clk);
        #5;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Central hazard scheduler for the 5-stage pipeline.
- Drives the enable and clear inputs of the PC, IF/ID and ID/EX pipeline registers.
- Decides stalls from Tuse/Tnew register hazards and from occupancy of the multi-cycle multiply/divide unit (MDU), which it tracks with an internal busy counter.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- MULT_CYCLES, 5: cycles the MDU stays busy after a mult/multu enters EX.
- DIV_CYCLES, 10: cycles the MDU stays busy after a div/divu enters EX.
- CNT_WIDTH, 4: width of the MDU busy counter. Must hold max(MULT_CYCLES, DIV_CYCLES).
- PERF_WIDTH, 32: width of the stall performance counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- id_rs_addr  input  5  rs index of the instruction in ID.
- id_rt_addr  input  5  rt index of the instruction in ID.
- id_rs_tuse  input  2  cycles until ID needs rs; 3 = rs unused.
- id_rt_tuse  input  2  cycles until ID needs rt; 3 = rt unused.
- ex_dst_addr  input  5  destination register of the instruction in EX; 0 = none.
- ex_tnew  input  2  cycles until the EX result is forwardable.
- mem_dst_addr  input  5  destination register of the instruction in MEM; 0 = none.
- mem_tnew  input  2  cycles until the MEM result is forwardable.
- id_md_start  input  1  ID holds mult/multu/div/divu.
- id_md_is_div  input  1  qualifies id_md_start: 1 = div/divu.
- id_md_use  input  1  ID holds mfhi/mflo/mthi/mtlo or an MDU start.
- pc_enable  output  1  PC register enable.
- if_id_enable  output  1  IF/ID register enable.
- id_ex_clear  output  1  synchronous clear of ID/EX (inserts a bubble).
- md_busy  output  1  MDU busy (md_count != 0).
- md_count  output  CNT_WIDTH  remaining MDU busy cycles.
- md_done  output  1  one-cycle pulse in the cycle md_count goes 1 -> 0.
- stall_count  output  PERF_WIDTH  number of stalled cycles since reset, saturating.

Behaviour:
- Reset (reset=0, asynchronous):
  - md_count=0, md_done=0, stall_count=0.
  - Combinational outputs then evaluate to pc_enable=1, if_id_enable=1, id_ex_clear=0, unless a register hazard is present on the inputs.
- Register hazard, combinational. For src in {rs, rt}, with tuse=3 never hazarding:
  - hz_ex = (src_addr != 0) && (src_addr == ex_dst_addr) && (src_tuse < ex_tnew).
  - hz_mem = (src_addr != 0) && (src_addr == mem_dst_addr) && (src_tuse < mem_tnew).
- MDU hazard, combinational: md_hz = id_md_use && md_busy.
- stall = any hz_ex | any hz_mem | md_hz.
- Outputs, combinational, same cycle as stall: pc_enable = ~stall; if_id_enable = ~stall; id_ex_clear = stall.
- MDU counter, registered:
  - Load: if id_md_start && !stall, load DIV_CYCLES when id_md_is_div, else MULT_CYCLES.
  - Decrement: else if md_count != 0, decrement by 1.
  - Hold: otherwise hold.
  - A start while stalled never loads; the start is retried when the stall releases.
  - Load and decrement never coincide, because a start while busy is always stalled via md_hz.
- md_done: registered; 1 for exactly one cycle after the edge where md_count transitions 1 -> 0, otherwise 0. A load never produces md_done.
- stall_count: increments on every rising edge where stall=1; holds at all-ones on overflow.
- Latency:
  - Hazard to stall: 0 cycles.
  - An MDU op issued at edge N makes md_busy=1 from after edge N through MULT_CYCLES/DIV_CYCLES edges.
  - A dependent mfhi is stalled exactly that long.
- Reset mid-operation: an in-flight MDU count is discarded immediately; md_busy=0 with no md_done pulse.
- No X propagation: every output is defined for any input combination once reset is deasserted.

Test Plan:
1. Load-use: ex_dst_addr=8, ex_tnew=2, id_rs_addr=8, id_rs_tuse=1 -> pc_enable=0, if_id_enable=0, id_ex_clear=1 that cycle. Next cycle (ex_tnew=1) -> no stall; stall_count=1.
2. Register $0: ex_dst_addr=0, id_rs_addr=0, id_rs_tuse=0, ex_tnew=2 -> stall=0. Also id_rt_tuse=3 with matching addr -> stall=0.
3. mult then mfhi: id_md_start=1, id_md_is_div=0 for one edge, then id_md_use=1 held -> md_count reads 5,4,3,2,1,0; stall=1 for 5 cycles; md_done pulses once; stall_count=5.
4. div issue blocked: register hazard present while id_md_start=1 -> md_count stays 0. Hazard removed -> md_count loads 10 on the next edge.
5. Reset mid-divide: md_count=6, reset=0 asynchronously between edges -> md_count=0, md_busy=0, stall_count=0 immediately; md_done stays 0 after release.
6. Saturation: PERF_WIDTH=4 with stall held for 20 cycles -> stall_count reaches 15 and holds.
